// File: rtl/seq_feed_arbiter_pkg.sv
// Shared definitions for the sequence-detector feed arbiter: FSM encoding and default sizes.
package seq_feed_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] S_LOAD  = 2'd1;
   localparam logic [STATE_W-1:0] S_SHIFT = 2'd2;
   localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

   localparam int NREQ_DEF   = 2;
   localparam int WORD_W_DEF = 8;
   localparam int CNT_W_DEF  = 5;

endpackage

// File: rtl/seq_feed_arbiter_if.sv
// Requester/detector-side bundle of the feed arbiter; master drives jobs, slave is the arbiter.
interface seq_feed_arbiter_if
   import seq_feed_pkg::*;
   #(
   parameter int NREQ   = NREQ_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
   );

   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0]        req;
   logic [NREQ*WORD_W-1:0] data;
   logic [NREQ-1:0]        gnt;
   logic                   busy;
   logic                   q;
   logic                   det_init;
   logic                   det_z;
   logic                   done;
   logic [IDX_W-1:0]       done_id;
   logic [CNT_W-1:0]       hit_count;

   modport master (
      output req, data, det_z,
      input  gnt, busy, q, det_init, done, done_id, hit_count
   );

   modport slave (
      input  req, data, det_z,
      output gnt, busy, q, det_init, done, done_id, hit_count
   );

endinterface

// File: rtl/seq_feed_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo NREQ.
module rr_pick
   import seq_feed_pkg::*;
   #(
   parameter int NREQ = NREQ_DEF
   ) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         win,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any_valid
   );

   localparam int IDX_W = $clog2(NREQ);

   int p;

   always_comb begin
      win       = '0;
      idx       = '0;
      any_valid = 1'b0;
      p         = 0;
      for (int k = 0; k < NREQ; k++) begin
         p = (int'(ptr) + k) % NREQ;
         if (!any_valid && req[p]) begin
            any_valid = 1'b1;
            idx       = IDX_W'(p);
            win[p]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_feed_arbiter.sv
// Round-robin feeder for the shared serial sequence detector; shifts a granted word MSB-first and counts z hits.
// Build option: define SEQ_FEED_DET_RESET_EN to pulse det_init low during LOAD so each job starts the detector fresh.
module seq_feed_arbiter
   import seq_feed_pkg::*;
   #(
   parameter int NREQ   = NREQ_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
   ) (
   input  logic              clk,
   input  logic              init,
   seq_feed_arbiter_if.slave bus
   );

   localparam int IDX_W = $clog2(NREQ);
   localparam int BIT_W = $clog2(WORD_W + 1);

   logic [STATE_W-1:0] state;
   logic [NREQ-1:0]    gnt_r;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   done_id_r;
   logic [CNT_W-1:0]   hits;
   logic [BIT_W-1:0]   bitcnt;
   logic [WORD_W-1:0]  sreg;

   logic [NREQ-1:0]    pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
      return (w == IDX_W'(NREQ - 1)) ? '0 : w + IDX_W'(1);
   endfunction

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req       (bus.req),
      .ptr       (ptr),
      .win       (pick_oh),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         state     <= S_IDLE;
         gnt_r     <= '0;
         ptr       <= '0;
         win_idx   <= '0;
         done_id_r <= '0;
         hits      <= '0;
         bitcnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  state   <= S_LOAD;
                  gnt_r   <= pick_oh;
                  win_idx <= pick_idx;
                  hits    <= '0;
               end
            end
            S_LOAD: begin
               state  <= S_SHIFT;
               bitcnt <= '0;
            end
            S_SHIFT: begin
               // det_z here reflects the detector's sample of the bit currently on q
               if (bus.det_z) hits <= sat_inc(hits);
               bitcnt <= bitcnt + BIT_W'(1);
               if (bitcnt == BIT_W'(WORD_W - 1)) begin
                  state     <= S_DONE;
                  done_id_r <= win_idx;
                  ptr       <= next_ptr(win_idx);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               gnt_r <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Shift register is pure data: q is gated by state, so it needs no reset
   always_ff @(posedge clk) begin
      if (state == S_IDLE && pick_any)
         sreg <= bus.data[pick_idx*WORD_W +: WORD_W];
      else if (state == S_SHIFT)
         sreg <= sreg << 1;
   end

   assign bus.gnt       = gnt_r;
   assign bus.busy      = (state != S_IDLE);
   assign bus.q         = (state == S_SHIFT) & sreg[WORD_W-1];
   assign bus.done      = (state == S_DONE);
   assign bus.done_id   = done_id_r;
   assign bus.hit_count = hits;

`ifdef SEQ_FEED_DET_RESET_EN
   assign bus.det_init = (state != S_LOAD);
`else
   assign bus.det_init = 1'b1;
`endif

endmodule
